uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/uart_tx_arb.sv | 117 +++++++++++
 tb/tb_uart_tx_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART arbiter state encodings and constants
package uart_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO
    } uart_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the pointer index
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);
    logic [$clog2(N)-1:0] idx;
    logic                 found;
    // first requester found walking upward from ptr_i+1 with wrap
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ($clog2(N))'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbitration of byte packets onto one UART transmitter
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1250
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [BYTE_W*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic [BYTE_W-1:0]       o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_busy,
    output logic                    o_timeout
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    uart_state_e       state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d, arb_gnt;
    logic [PW-1:0]     ptr_q, ptr_d, gidx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d, timeout_q, timeout_d;
    logic [BYTE_W-1:0] data_q, data_d, sel_data;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i (i_req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    assign o_grant     = grant_q;
    assign o_tx_data   = data_q;
    assign o_timeout   = timeout_q;
    assign o_req_ready = (state_q == LOAD) ? grant_q : '0;
    assign o_tx_start  = (state_q == START) && !i_tx_busy;

    // index and byte of the current owner, used for pointer advance and capture
    always_comb begin
        gidx = '0;
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                gidx = PW'(k);
                sel_data = i_req_data[BYTE_W*k +: BYTE_W];
            end
        end
    end

    // next-state logic; the pointer only moves when a grant is released
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        last_d = last_q;
        data_d = data_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: if (|i_req_valid) begin
                grant_d = arb_gnt;
                state_d = LOAD;
            end
            LOAD: if (|(i_req_valid & grant_q)) begin
                data_d = sel_data;
                last_d = |(i_req_last & grant_q);
                cnt_d = '0;
                state_d = START;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                grant_d = '0;
                timeout_d = 1'b1;
                ptr_d = gidx;
                cnt_d = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            START: if (!i_tx_busy) state_d = WAIT_HI;
            WAIT_HI: if (i_tx_busy) state_d = WAIT_LO;
            WAIT_LO: if (!i_tx_busy) begin
                if (last_q) begin
                    grant_d = '0;
                    ptr_d = gidx;
                    state_d = IDLE;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset makes requester 0 the first round-robin choice
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q <= PW'(N_REQ - 1);
            cnt_q <= '0;
            last_q <= 1'b0;
            data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            data_q <= data_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed checks of arbitration, packets, timeout, busy stall and reset
module tb_uart_tx_arb;
    localparam int N = 4;
    localparam int T = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   valid = '0, last = '0;
    logic [8*N-1:0] data = '0;
    logic [N-1:0]   ready, grant;
    logic [7:0]     tx_data;
    logic           tx_start, timeout, busy;
    logic           hold_busy = 1'b0;
    int             bcnt = 0;
    logic [11:0]    log_q[$];
    int             n_chk = 0, n_fail = 0;

    uart_tx_arb #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (valid),
        .i_req_data  (data),
        .i_req_last  (last),
        .o_req_ready (ready),
        .o_grant     (grant),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_busy   (busy),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    assign busy = (bcnt != 0) || hold_busy;

    always @(posedge clk) begin
        if (tx_start) begin
            bcnt <= 4;
            log_q.push_back({grant, tx_data});
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        data[8*k +: 8] = d;
        last[k] = l;
        valid[k] = 1'b1;
        for (int i = 0; i < 200 && !ready[k]; i++) step();
        check($sformatf("ready%0d", k), 32'(ready[k]), 1);
        step();
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && (grant != '0 || busy); i++) step();
        check(tag, 32'(grant), 0);
    endtask

    task automatic pop(input string tag, input logic [11:0] exp);
        logic [11:0] v;
        v = (log_q.size() != 0) ? log_q.pop_front() : 12'hxxx;
        check(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        logic s;
        step();
        step();
        check("rst_grant", 32'(grant), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_start", 32'(tx_start), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_data", 32'(tx_data), 0);
        rst = 1'b0;
        step();

        // single-byte packet from requester 2
        data[23:16] = 8'h41;
        last[2] = 1'b1;
        valid[2] = 1'b1;
        step();
        check("t1_grant", 32'(grant), 32'h4);
        check("t1_ready", 32'(ready), 32'h4);
        step();
        valid[2] = 1'b0;
        check("t1_start", 32'(tx_start), 1);
        check("t1_data", 32'(tx_data), 32'h41);
        check("t1_ready_lo", 32'(ready), 0);
        wait_idle("t1_idle");
        pop("t1_log", {4'b0100, 8'h41});

        // simultaneous requesters 0 and 1, each one byte
        data[15:8] = 8'hB1;
        last[1] = 1'b1;
        valid[1] = 1'b1;
        push(0, 8'hA0, 1'b1);
        push(1, 8'hB1, 1'b1);
        wait_idle("t2_idle");
        pop("t2_log0", {4'b0001, 8'hA0});
        pop("t2_log1", {4'b0010, 8'hB1});

        // three-byte packet from requester 3 while requester 1 waits
        data[15:8] = 8'h55;
        last[1] = 1'b1;
        valid[1] = 1'b1;
        push(3, 8'h10, 1'b0);
        push(3, 8'h20, 1'b0);
        push(3, 8'h30, 1'b1);
        check("t3_hold", 32'(grant), 32'h8);
        push(1, 8'h55, 1'b1);
        wait_idle("t3_idle");
        pop("t3_b0", {4'b1000, 8'h10});
        pop("t3_b1", {4'b1000, 8'h20});
        pop("t3_b2", {4'b1000, 8'h30});
        pop("t3_r1", {4'b0010, 8'h55});

        // requester 1 sends a non-last byte then goes silent
        push(1, 8'h77, 1'b0);
        for (int i = 0; i < 200 && ready != 4'b0010; i++) step();
        check("t4_reload", 32'(ready), 32'h2);
        s = timeout;
        for (int i = 1; i <= 7; i++) begin
            step();
            s |= timeout;
        end
        check("t4_early", 32'(s), 0);
        check("t4_held", 32'(grant), 32'h2);
        step();
        check("t4_pulse", 32'(timeout), 1);
        check("t4_revoke", 32'(grant), 0);
        step();
        check("t4_pulse_end", 32'(timeout), 0);
        pop("t4_log", {4'b0010, 8'h77});

        // transmitter busy on entry to START stalls the strobe
        hold_busy = 1'b1;
        push(2, 8'h99, 1'b1);
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s |= tx_start;
            step();
        end
        check("t5_stall", 32'(s), 0);
        hold_busy = 1'b0;
        #1;
        check("t5_start", 32'(tx_start), 1);
        check("t5_data", 32'(tx_data), 32'h99);
        wait_idle("t5_idle");
        pop("t5_log", {4'b0100, 8'h99});

        // reset during WAIT_LO abandons the packet and restores priority
        push(3, 8'hAB, 1'b0);
        for (int i = 0; i < 50 && !tx_start; i++) step();
        check("t6_start", 32'(tx_start), 1);
        step();
        step();
        step();
        data[7:0] = 8'h01;
        last[0] = 1'b1;
        valid[0] = 1'b1;
        data[31:24] = 8'hCD;
        last[3] = 1'b1;
        valid[3] = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("t6_grant", 32'(grant), 0);
        check("t6_ready", 32'(ready), 0);
        check("t6_start_lo", 32'(tx_start), 0);
        check("t6_data", 32'(tx_data), 0);
        check("t6_timeout", 32'(timeout), 0);
        step();
        step();
        rst = 1'b0;
        check("t6_rel_start", 32'(tx_start), 0);
        step();
        check("t6_rel_start2", 32'(tx_start), 0);
        check("t6_prio", 32'(grant), 32'h1);
        push(0, 8'h01, 1'b1);
        push(3, 8'hCD, 1'b1);
        wait_idle("t6_idle");
        pop("t6_log0", {4'b1000, 8'hAB});
        pop("t6_log1", {4'b0001, 8'h01});
        pop("t6_log2", {4'b1000, 8'hCD});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
